// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared constants for the VGA path: tile framebuffer geometry, colour
//   width, pixel-generator state encoding, and the 800x600 timing numbers
//   used by the upstream timing generator (1040x666 total).
// ---------------------------------------------------------------------------
package vga_pkg;

    // Tile framebuffer geometry
    localparam int CELL     = 25;               // pixels per tile edge
    localparam int COLS     = 32;               // tiles per row (power of two)
    localparam int ROWS     = 24;               // tile rows
    localparam int COLOR_W  = 6;                // RRGGBB
    localparam int FB_DEPTH = ROWS * COLS;      // 768 tiles
    localparam int ADDR_W   = 10;
    localparam int COL_B    = $clog2(COLS);     // column bits of a tile address
    localparam int ROW_B    = ADDR_W - COL_B;   // row bits of a tile address

    // Horizontal timing (pixels)
    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 56;
    localparam int H_SYNC   = 120;
    localparam int H_BACK   = 64;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;   // 1040

    // Vertical timing (lines)
    localparam int V_ACTIVE = 600;
    localparam int V_FRONT  = 37;
    localparam int V_SYNC   = 6;
    localparam int V_BACK   = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;   // 666

    typedef enum logic {
        CLEAR = 1'b0,   // walking the framebuffer, writing zeros
        RUN   = 1'b1    // normal display + processor writes
    } pg_state_t;

    // Tile index row*COLS+col; COLS is a power of two so this is a concat.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROW_B-1:0] row,
                                                     input logic [COL_B-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/tile_ram.sv
// ---------------------------------------------------------------------------
// tile_ram
//   Single-port tile colour store, synchronous read with one cycle of
//   latency, write-first (a write cycle returns the written data). No reset
//   on the array or output register so it maps onto block RAM.
// Ports
//   clk       clock
//   we_i      write enable for this cycle (otherwise a read)
//   addr_i    tile address, must be < DEPTH when we_i is set
//   wdata_i   write data
//   rdata_o   registered read data
// ---------------------------------------------------------------------------
module tile_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int WIDTH = COLOR_W,
    parameter int AW    = ADDR_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_gen.sv
// ---------------------------------------------------------------------------
// vga_pixel_gen
//   Turns the timing generator's sync/enable stream into pixel colour from
//   a 32x24 tile framebuffer (25x25-pixel tiles) written by the processor.
//   After reset the framebuffer is zeroed (CLEAR), then display runs (RUN).
//   Colour and syncs leave two cycles after the inputs, mutually aligned.
// Ports
//   clk, rst        pixel clock, synchronous active-high reset
//   hsync_in        active-low hsync          -> hsync_out (2-cycle delay)
//   vsync_in        active-low vsync          -> vsync_out (2-cycle delay)
//   color_en_in     1 = active pixel this cycle
//   wr_valid/ready  processor write handshake (tile address + colour)
//   wr_addr         tile index row*COLS+col; >= FB_DEPTH is dropped
//   wr_data         tile colour
//   rgb_out         pixel colour, 0 outside active video and during CLEAR
// ---------------------------------------------------------------------------
module vga_pixel_gen
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               color_en_in,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [COLOR_W-1:0] rgb_out
);

    localparam int PW  = $clog2(CELL);   // in-tile pixel counter width
    localparam int CXW = COL_B + 1;      // one spare bit so cx can sit at COLS
    localparam int CYW = ROW_B + 1;

    localparam logic [PW-1:0]     P_LAST    = PW'(CELL - 1);
    localparam logic [CXW-1:0]    CX_END    = CXW'(COLS);
    localparam logic [CYW-1:0]    CY_END    = CYW'(ROWS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FB_DEPTH - 1);

    // FSM
    pg_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Pixel position inside the frame
    logic [PW-1:0]  px_q, px_d, py_q, py_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic           ce_prev_q, vs_prev_q;
    logic           ce_fall, vs_fall;

    // One-entry write buffer
    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [COLOR_W-1:0] pend_data_q, pend_data_d;
    logic               commit;

    // Display pipeline
    logic               in_range, pix_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [1:0]         hs_dly_q, vs_dly_q;
    logic               en_q;
    logic [COLOR_W-1:0] rgb_q, rgb_d;

    // RAM port
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [COLOR_W-1:0] ram_wdata, ram_rdata;

    // ---------------- FSM ----------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_LAST) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end
            end
            RUN: begin
            end
        endcase
    end

    // ---------------- pixel position ----------------
    assign ce_fall = ce_prev_q & ~color_en_in;
    assign vs_fall = vs_prev_q & ~vsync_in;

    always_comb begin
        px_d = px_q;
        cx_d = cx_q;
        py_d = py_q;
        cy_d = cy_q;
        if (color_en_in) begin
            if (px_q == P_LAST) begin
                px_d = '0;
                // cx parks at COLS past the last tile so the address saturates
                if (cx_q != CX_END) cx_d = cx_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end
        if (ce_fall) begin
            px_d = '0;
            cx_d = '0;
            if (py_q == P_LAST) begin
                py_d = '0;
                if (cy_q != CY_END) cy_d = cy_q + 1'b1;
            end else begin
                py_d = py_q + 1'b1;
            end
        end
        // vsync fall wins over a coincident line end
        if (vs_fall) begin
            py_d = '0;
            cy_d = '0;
        end
    end

    assign in_range = (cx_q < CX_END) && (cy_q < CY_END);
    assign rd_addr  = in_range ? tile_addr(cy_q[ROW_B-1:0], cx_q[COL_B-1:0]) : ADDR_LAST;
    assign pix_en   = color_en_in & in_range & (state_q == RUN);

    // ---------------- write buffer ----------------
    assign wr_ready = (state_q == RUN) & ~pend_valid_q;
    // Commits only in blank cycles, so the display never loses a read slot.
    assign commit   = pend_valid_q & ~color_en_in & ~rst;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (commit) begin
            pend_valid_d = 1'b0;
        end else if (wr_valid && wr_ready) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = wr_addr;
            pend_data_d  = wr_data;
        end
    end

    // ---------------- RAM port arbitration ----------------
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = rd_addr;
        ram_wdata = pend_data_q;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr_q;
            ram_wdata = '0;
        end else if (commit) begin
            // out-of-range addresses are accepted but never reach the array
            ram_we   = (pend_addr_q <= ADDR_LAST);
            ram_addr = pend_addr_q;
        end
    end

    tile_ram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (COLOR_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // en_q lines up with the RAM output register; rgb_q is the second stage.
    assign rgb_d = en_q ? ram_rdata : '0;

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            px_q         <= '0;
            cx_q         <= '0;
            py_q         <= '0;
            cy_q         <= '0;
            ce_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            hs_dly_q     <= 2'b11;
            vs_dly_q     <= 2'b11;
            en_q         <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            px_q         <= px_d;
            cx_q         <= cx_d;
            py_q         <= py_d;
            cy_q         <= cy_d;
            ce_prev_q    <= color_en_in;
            vs_prev_q    <= vsync_in;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            hs_dly_q     <= {hs_dly_q[0], hsync_in};
            vs_dly_q     <= {vs_dly_q[0], vsync_in};
            en_q         <= pix_en;
            rgb_q        <= rgb_d;
        end
    end

    assign hsync_out = hs_dly_q[1];
    assign vsync_out = vs_dly_q[1];
    assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_gen
//   Drives sync/enable streams and processor writes; a reference model keeps
//   the framebuffer as a plain array and derives each pixel's colour from its
//   (x, y) position within the frame. Outputs are compared two cycles later.
// ---------------------------------------------------------------------------
module tb_vga_pixel_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, color_en_in = 1'b0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [9:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic       hsync_out, vsync_out;
    logic [5:0] rgb_out;

    vga_pixel_gen dut (
        .clk         (clk),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .color_en_in (color_en_in),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .rgb_out     (rgb_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // stimulus for the next cycle
    bit         rst_v = 1'b1, ce_v = 1'b0, hs_v = 1'b1, vs_v = 1'b1;
    bit         wq_valid = 1'b0;
    logic [9:0] wq_addr = '0;
    logic [5:0] wq_data = '0;

    // reference model
    logic [5:0] fb [768];
    int         m_x = 0, m_y = 0, m_clr = 768;
    bit         m_pce = 1'b0, m_pvs = 1'b1, m_run = 1'b0, m_pend = 1'b0;
    int         m_paddr = 0;
    logic [5:0] m_pdata = '0;
    logic [5:0] e1_rgb = '0, e2_rgb = '0;
    bit         e1_hs = 1'b1, e2_hs = 1'b1, e1_vs = 1'b1, e2_vs = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One pixel clock: check outputs due now, drive inputs, advance the model.
    task automatic cyc();
        logic [5:0] pix;
        @(negedge clk);
        chk("rgb_out",   rgb_out,   e2_rgb);
        chk("hsync_out", hsync_out, e2_hs);
        chk("vsync_out", vsync_out, e2_vs);
        chk("wr_ready",  wr_ready,  m_run && !m_pend);
        rst         = rst_v;
        color_en_in = ce_v;
        hsync_in    = hs_v;
        vsync_in    = vs_v;
        wr_valid    = wq_valid;
        wr_addr     = wq_addr;
        wr_data     = wq_data;
        if (rst_v) begin
            e2_rgb = '0; e2_hs = 1'b1; e2_vs = 1'b1;
            e1_rgb = '0; e1_hs = 1'b1; e1_vs = 1'b1;
            m_run = 1'b0; m_clr = 768; m_pend = 1'b0;
            m_x = 0; m_y = 0; m_pce = 1'b0; m_pvs = 1'b1;
            foreach (fb[i]) fb[i] = '0;
        end else begin
            pix = '0;
            if (m_run && ce_v && m_x < 800 && m_y < 600)
                pix = fb[(m_y / 25) * 32 + m_x / 25];
            e2_rgb = e1_rgb; e2_hs = e1_hs; e2_vs = e1_vs;
            e1_rgb = pix;    e1_hs = hs_v;  e1_vs = vs_v;
            if (m_pend && !ce_v) begin
                if (m_paddr < 768) fb[m_paddr] = m_pdata;
                m_pend = 1'b0;
            end else if (wq_valid && m_run && !m_pend) begin
                m_pend = 1'b1; m_paddr = int'(wq_addr); m_pdata = wq_data;
                wq_valid = 1'b0;
            end
            if (m_pce && !ce_v) begin m_x = 0; m_y++; end
            else if (ce_v) m_x++;
            if (m_pvs && !vs_v) m_y = 0;
            m_pce = ce_v; m_pvs = vs_v;
            if (m_clr > 0) begin
                m_clr--;
                if (m_clr == 0) m_run = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        ce_v = 1'b0; hs_v = 1'b1; vs_v = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic vpulse();
        ce_v = 1'b0; hs_v = 1'b1; vs_v = 1'b0;
        repeat (3) cyc();
        vs_v = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic line(input int act, input int blank);
        ce_v = 1'b1; hs_v = 1'b1;
        repeat (act) cyc();
        ce_v = 1'b0;
        for (int b = 0; b < blank; b++) begin
            hs_v = !(b >= 1 && b < 4);
            cyc();
        end
        hs_v = 1'b1;
    endtask

    task automatic frame(input int nlines, input int act, input int blank);
        vpulse();
        repeat (nlines) line(act, blank);
    endtask

    task automatic do_reset();
        int first;
        rst_v = 1'b1; ce_v = 1'b0; hs_v = 1'b1; vs_v = 1'b1;
        cyc();
        rst_v = 1'b0;
        first = 0;
        for (int i = 1; i <= 772; i++) begin
            cyc();
            if (first == 0 && wr_ready) first = i;
        end
        chk("ready_cycle", first, 769);
    endtask

    initial begin
        repeat (2) @(negedge clk);

        // clear sequence, then a whole frame of zeros
        do_reset();
        frame(30, 60, 8);

        // tile 0 written in blanking, shown next frame
        wq_valid = 1'b1; wq_addr = 10'd0; wq_data = 6'h3F;
        idle(4);
        frame(27, 60, 8);

        // write arriving during active video waits for the first blank cycle
        idle(2);
        wq_valid = 1'b1; wq_addr = 10'd33; wq_data = 6'h0C;
        line(60, 8);
        frame(52, 60, 8);

        // last tile and a discarded out-of-range write
        wq_valid = 1'b1; wq_addr = 10'd767; wq_data = 6'h15;
        idle(3);
        wq_valid = 1'b1; wq_addr = 10'd800; wq_data = 6'h2A;
        idle(3);
        vpulse();
        repeat (599) line(1, 3);
        line(800, 20);

        // random sync/enable stream with random writes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ce_v = !ce_v;
            hs_v = ($urandom_range(0, 3) != 0);
            vs_v = ($urandom_range(0, 399) != 0);
            if (!wq_valid && $urandom_range(0, 29) == 0) begin
                wq_valid = 1'b1;
                wq_addr  = $urandom_range(0, 1) ? 10'($urandom_range(0, 95))
                                                : 10'($urandom_range(0, 1023));
                wq_data  = 6'($urandom);
            end
            cyc();
        end
        ce_v = 1'b0; hs_v = 1'b1; vs_v = 1'b1;
        for (int k = 0; k < 50 && wq_valid; k++) cyc();
        chk("write_drain", wq_valid, 0);
        idle(4);

        // reset mid-line with a write pending
        vpulse();
        line(60, 8);
        wq_valid = 1'b1; wq_addr = 10'd1; wq_data = 6'h2A;
        ce_v = 1'b1;
        repeat (10) cyc();
        chk("pend_ready", wr_ready, 0);
        rst_v = 1'b1;
        cyc();
        rst_v = 1'b0; ce_v = 1'b0;
        cyc();
        chk("rst_rgb",   rgb_out,   0);
        chk("rst_hsync", hsync_out, 1);
        chk("rst_vsync", vsync_out, 1);
        chk("rst_ready", wr_ready,  0);
        idle(780);
        frame(27, 60, 8);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
